// File: rtl/lockpick_host.sv
// Host-side initiator for the lockpick game: optional start pulse, byte-serial key A then key B,
// capture of the result message with idle timeout, then decode and cross-check against game status.
module lockpick_host #(
  parameter int KEY_BYTES = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [KEY_BYTES*8-1:0] key_a,
  input  logic [KEY_BYTES*8-1:0] key_b,
  output logic                   busy,
  output logic                   game_start,
  output logic                   game_input_enable,
  output logic [7:0]             game_input_data,
  input  logic                   game_output_valid,
  input  logic [7:0]             game_output_data,
  input  logic [1:0]             game_status,
  output logic                   done,
  output logic [1:0]             result_code,
  output logic                   msg_ok,
  output logic                   timed_out,
  output logic [KEY_BYTES*8-1:0] result_msg,
  output logic                   need_start
);

  localparam int KW = KEY_BYTES * 8;
  localparam int CW = $clog2(KEY_BYTES);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, SEND_A, SEND_B, WAIT, RECV, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [KW-1:0]   key_a_q, key_b_q;
  logic [KW-1:0]   msg_buf, msg_fin, send_key;
  logic            accept, store, finish, fin_timeout, send_en;
  logic [1:0]      dec;

  function automatic logic [1:0] decode(input logic [KW-1:0] m);
    logic face, dead, bad;
    logic [1:0] r;
    face = 1'b1;
    dead = 1'b1;
    bad  = 1'b1;
    for (int i = 0; i < KW / 32; i++) begin
      face = face & (m[i*32 +: 32] == 32'hFACEFACE);
      dead = dead & (m[i*32 +: 32] == 32'hDEADDEAD);
      bad  = bad  & (m[i*32 +: 32] == 32'hBAD0BAD0);
    end
    if (face)      r = 2'b10;
    else if (dead) r = 2'b11;
    else if (bad)  r = 2'b01;
    else           r = 2'b00;
    return r;
  endfunction

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    tcnt_nx     = tcnt;
    accept      = 1'b0;
    store       = 1'b0;
    finish      = 1'b0;
    fin_timeout = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (go) begin
          accept   = 1'b1;
          cnt_nx   = '0;
          tcnt_nx  = '0;
          state_nx = need_start ? START : SEND_A;
        end else if (state == DONE) begin
          state_nx = IDLE;
        end
      end
      START: state_nx = SEND_A;
      SEND_A: begin
        if (cnt == CW'(KEY_BYTES - 1)) begin
          cnt_nx   = '0;
          state_nx = SEND_B;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      SEND_B: begin
        if (cnt == CW'(KEY_BYTES - 1)) begin
          cnt_nx   = '0;
          tcnt_nx  = '0;
          state_nx = WAIT;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      // WAIT always has cnt=0, so the first byte lands at index 0 like any other.
      WAIT, RECV: begin
        if (game_output_valid) begin
          store   = 1'b1;
          tcnt_nx = '0;
          if (cnt == CW'(KEY_BYTES - 1)) begin
            cnt_nx   = '0;
            finish   = 1'b1;
            state_nx = DONE;
          end else begin
            cnt_nx   = cnt + CW'(1);
            state_nx = RECV;
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          finish      = 1'b1;
          fin_timeout = 1'b1;
          cnt_nx      = '0;
          state_nx    = DONE;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    msg_fin = msg_buf;
    if (store) msg_fin[{cnt, 3'b000} +: 8] = game_output_data;
    send_en = (state_nx == SEND_A) || (state_nx == SEND_B);
    // On the accepting edge the key register is not loaded yet, so key A comes straight from the port.
    if (state_nx == SEND_B) send_key = key_b_q;
    else if (accept)        send_key = key_a;
    else                    send_key = key_a_q;
    dec = fin_timeout ? 2'b00 : decode(msg_fin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      tcnt              <= '0;
      key_a_q           <= '0;
      key_b_q           <= '0;
      msg_buf           <= '0;
      busy              <= 1'b0;
      game_start        <= 1'b0;
      game_input_enable <= 1'b0;
      game_input_data   <= 8'h00;
      done              <= 1'b0;
      result_code       <= 2'b00;
      msg_ok            <= 1'b0;
      timed_out         <= 1'b0;
      result_msg        <= '0;
      need_start        <= 1'b1;
    end else begin
      state             <= state_nx;
      cnt               <= cnt_nx;
      tcnt              <= tcnt_nx;
      game_start        <= (state_nx == START);
      game_input_enable <= send_en;
      game_input_data   <= send_en ? send_key[{cnt_nx, 3'b000} +: 8] : 8'h00;
      done              <= finish;
      msg_buf           <= accept ? '0 : msg_fin;
      if (accept) begin
        key_a_q     <= key_a;
        key_b_q     <= key_b;
        busy        <= 1'b1;
        result_code <= 2'b00;
        msg_ok      <= 1'b0;
        timed_out   <= 1'b0;
        result_msg  <= '0;
      end else if (finish) begin
        busy        <= 1'b0;
        result_code <= dec;
        msg_ok      <= (dec != 2'b00) && (dec == game_status) && !fin_timeout;
        timed_out   <= fin_timeout;
        result_msg  <= msg_fin;
        // Only a clean error leaves the game waiting for a retry without start.
        need_start  <= fin_timeout || (dec != 2'b01);
      end
    end
  end

endmodule
